// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WB_DATA_W  = 32;

  // One pending register-file write: destination register and data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

  // One-hot mask of a destination register; x0 never appears in the mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] mask;
    mask = {NUM_REGS{1'b0}};
    if (rd != {REG_ADDR_W{1'b0}}) begin
      mask[rd] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular queue of pending long-latency writebacks.
// Exposes the head entry plus every slot's register and valid bit so the
// parent can build the pending-register mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [REG_ADDR_W-1:0]       push_rd,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  output logic [REG_ADDR_W-1:0]       head_rd,
  output logic [DATA_WIDTH-1:0]       head_data,
  output logic [CNT_W-1:0]            count,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [DEPTH*REG_ADDR_W-1:0] entry_rd
);

  logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == {CNT_W{1'b0}});
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Slot i is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset         = PTR_W'(i) - rd_ptr;
    assign entry_valid[i] = ({1'b0, offset} < count);
    assign entry_rd[i*REG_ADDR_W +: REG_ADDR_W] = rd_mem[i];
  end

  // Storage write; contents need no reset because validity comes from count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the core writeback (C) and a
// long-latency unit (M). M results queue in wb_fifo; C wins unless the queue
// head has waited MAX_WAIT cycles, in which case the head is forced out and
// the core is stalled for that cycle.
// Optional build macro: WB_BYPASS_EN -- an accepted M result is written in
// its acceptance cycle when the queue is empty and the port is otherwise idle.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_WAIT   = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  coreWbValid,
  input  logic [4:0]            coreWbReg,
  input  logic [DATA_WIDTH-1:0] coreWbData,
  output logic                  stallCore,
  input  logic                  mWbValid,
  output logic                  mWbReady,
  input  logic [4:0]            mWbReg,
  input  logic [DATA_WIDTH-1:0] mWbData,
  output logic                  regWriteEnable,
  output logic [4:0]            writeRegister,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic [31:0]           pendingMask
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [REG_ADDR_W-1:0]       head_rd;
  logic [DATA_WIDTH-1:0]       head_data;
  logic [CNT_W-1:0]            count;
  logic                        full;
  logic                        empty;
  logic [DEPTH-1:0]            entry_valid;
  logic [DEPTH*REG_ADDR_W-1:0] entry_rd;
  logic [WAIT_W-1:0]           wait_cnt;
  logic                        force_wr;
  logic                        c_req;
  logic                        m_accept;
  logic                        pop;
  logic                        push;
  logic                        bypass_take;

  assign c_req    = coreWbValid && (coreWbReg != 5'd0);
  assign mWbReady = !full && !reset;
  assign m_accept = mWbValid && mWbReady;
  assign force_wr = (count != {CNT_W{1'b0}}) && (wait_cnt == WAIT_W'(MAX_WAIT));
  // x0 results are accepted but never queued; bypassed results skip the queue.
  assign push     = m_accept && (mWbReg != 5'd0) && !bypass_take;

  wb_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_rd     (mWbReg),
    .push_data   (mWbData),
    .pop         (pop),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // Write-port selection: forced head, then core, then queue head, then optional bypass.
  always_comb begin
    regWriteEnable = 1'b0;
    writeRegister  = 5'd0;
    writeData      = {DATA_WIDTH{1'b0}};
    stallCore      = 1'b0;
    pop            = 1'b0;
    bypass_take    = 1'b0;
    if (reset) begin
      regWriteEnable = 1'b0;
    end else if (force_wr) begin
      regWriteEnable = 1'b1;
      writeRegister  = head_rd;
      writeData      = head_data;
      pop            = 1'b1;
      stallCore      = c_req;
    end else if (c_req) begin
      regWriteEnable = 1'b1;
      writeRegister  = coreWbReg;
      writeData      = coreWbData;
    end else if (count != {CNT_W{1'b0}}) begin
      regWriteEnable = 1'b1;
      writeRegister  = head_rd;
      writeData      = head_data;
      pop            = 1'b1;
    end else begin
`ifdef WB_BYPASS_EN
      if (m_accept && (mWbReg != 5'd0)) begin
        regWriteEnable = 1'b1;
        writeRegister  = mWbReg;
        writeData      = mWbData;
        bypass_take    = 1'b1;
      end else begin
        regWriteEnable = 1'b0;
      end
`else
      regWriteEnable = 1'b0;
`endif
    end
  end

  // Head age counter: restarts on every dequeue or when nothing is queued, saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= {WAIT_W{1'b0}};
    end else if (pop || empty) begin
      wait_cnt <= {WAIT_W{1'b0}};
    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Registers with a queued write outstanding, for the hazard unit.
  always_comb begin
    pendingMask = 32'd0;
    if (reset) begin
      pendingMask = 32'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_valid[i]) begin
          pendingMask = pendingMask | reg_onehot(entry_rd[i*REG_ADDR_W +: REG_ADDR_W]);
        end else begin
          pendingMask = pendingMask;
        end
      end
      pendingMask[0] = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. Expected writes are queued per source
// (C uses registers 16..31, M uses 1..15) when driven and popped when the
// register-file port fires; cycle-exact checks cover latency, stall and mask.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        coreWbValid;
  logic [4:0]  coreWbReg;
  logic [31:0] coreWbData;
  logic        stallCore;
  logic        mWbValid;
  logic        mWbReady;
  logic [4:0]  mWbReg;
  logic [31:0] mWbData;
  logic        regWriteEnable;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [31:0] pendingMask;

  int errors = 0;
  int checks = 0;
  wb_entry_t cq[$];
  wb_entry_t mq[$];
  logic stall_seen;
  logic ready_seen;
  int c_id = 0;

  regfile_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .coreWbValid(coreWbValid), .coreWbReg(coreWbReg), .coreWbData(coreWbData),
    .stallCore(stallCore),
    .mWbValid(mWbValid), .mWbReady(mWbReady), .mWbReg(mWbReg), .mWbData(mWbData),
    .regWriteEnable(regWriteEnable), .writeRegister(writeRegister), .writeData(writeData),
    .pendingMask(pendingMask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    stall_seen = stallCore;
    ready_seen = mWbReady;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // New core request with a fresh register/data pair.
  task automatic new_c();
    wb_entry_t e;
    c_id++;
    coreWbValid = 1'b1;
    coreWbReg   = 5'(16 + (c_id % 16));
    coreWbData  = 32'hC000_0000 + 32'(c_id);
    e.rd = coreWbReg;
    e.data = coreWbData;
    cq.push_back(e);
  endtask

  // Core keeps its request while stalled, otherwise issues a new one.
  task automatic next_c();
    if (!stall_seen) new_c();
  endtask

  task automatic m_drive(input logic [4:0] rd, input logic [31:0] data);
    wb_entry_t e;
    mWbValid = 1'b1;
    mWbReg   = rd;
    mWbData  = data;
    e.rd = rd;
    e.data = data;
    if (rd != 5'd0) mq.push_back(e);
  endtask

  // Scoreboard: every register-file write must match the oldest expectation of its source.
  always @(negedge clk) begin
    wb_entry_t got;
    wb_entry_t exp;
    if (!reset && regWriteEnable === 1'b1) begin
      got.rd = writeRegister;
      got.data = writeData;
      chk("no_x0_write", 64'(writeRegister != 5'd0), 64'd1);
      if (writeRegister >= 5'd16) begin
        exp = (cq.size() != 0) ? cq.pop_front() : '0;
        chk("sb_core", 64'(got), 64'(exp));
      end else begin
        exp = (mq.size() != 0) ? mq.pop_front() : '0;
        chk("sb_m", 64'(got), 64'(exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [4:0] held_reg;
    reset = 1'b1;
    coreWbValid = 1'b0; coreWbReg = 5'd0; coreWbData = 32'd0;
    mWbValid = 1'b0; mWbReg = 5'd0; mWbData = 32'd0;
    sample();
    chk("rst_we", 64'(regWriteEnable), 64'd0);
    chk("rst_ready", 64'(mWbReady), 64'd0);
    chk("rst_mask", 64'(pendingMask), 64'd0);
    adv(); adv();
    reset = 1'b0;
    sample();
    chk("post_rst_ready", 64'(mWbReady), 64'd1);
    adv();

    // Test 1: three queued entries discarded by a two-cycle reset.
    for (int i = 0; i < 3; i++) begin
      new_c();
      mWbValid = 1'b1; mWbReg = 5'(i + 1); mWbData = 32'hDEAD_0000 + 32'(i);
      sample(); adv();
    end
    mWbValid = 1'b0;
    new_c();
    sample();
    chk("t1_mask3", 64'(pendingMask), 64'h0000_000E);
    adv();
    coreWbValid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("t1_rst_we", 64'(regWriteEnable), 64'd0);
      chk("t1_rst_stall", 64'(stallCore), 64'd0);
      chk("t1_rst_ready", 64'(mWbReady), 64'd0);
      chk("t1_rst_mask", 64'(pendingMask), 64'd0);
      adv();
    end
    reset = 1'b0;
    sample();
    chk("t1_empty_we", 64'(regWriteEnable), 64'd0);
    chk("t1_empty_mask", 64'(pendingMask), 64'd0);
    adv();

    // Test 2: lone M result x5.
    m_drive(5'd5, 32'h0000_1234);
    sample();
`ifdef WB_BYPASS_EN
    chk("t2_bypass_we", 64'(regWriteEnable), 64'd1);
    chk("t2_bypass_mask", 64'(pendingMask), 64'd0);
    adv(); mWbValid = 1'b0;
    sample();
    chk("t2_after_we", 64'(regWriteEnable), 64'd0);
`else
    chk("t2_t0_we", 64'(regWriteEnable), 64'd0);
    chk("t2_t0_mask", 64'(pendingMask), 64'd0);
    adv(); mWbValid = 1'b0;
    sample();
    chk("t2_t1_we", 64'(regWriteEnable), 64'd1);
    chk("t2_t1_reg", 64'(writeRegister), 64'd5);
    chk("t2_t1_mask", 64'(pendingMask), 64'h0000_0020);
    adv();
    sample();
    chk("t2_t2_mask", 64'(pendingMask), 64'd0);
    chk("t2_t2_we", 64'(regWriteEnable), 64'd0);
`endif
    adv();

    // Test 3: queue fills while the core writes every cycle.
    stall_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_c();
      m_drive(5'(i + 1), 32'h3000_0000 + 32'(i));
      sample();
      chk("t3_ready", 64'(ready_seen), 64'd1);
      adv();
    end
    next_c();
    m_drive(5'd6, 32'h3000_0006);
    sample();
    chk("t3_full_ready", 64'(ready_seen), 64'd0);
    n = 0;
    while (!ready_seen && n < 20) begin
      adv(); next_c(); sample(); n++;
    end
    chk("t3_fifth_accepted", 64'(ready_seen), 64'd1);
    adv();
    mWbValid = 1'b0;
    n = 0;
    while (stall_seen && n < 5) begin
      sample(); adv(); n++;
    end
    coreWbValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample(); adv();
    end
    chk("t3_m_drained", 64'(mq.size()), 64'd0);
    chk("t3_c_drained", 64'(cq.size()), 64'd0);

    // Test 4: starvation of queued x7 under continuous core traffic.
    stall_seen = 1'b0;
    new_c();
    m_drive(5'd7, 32'h0000_7777);
    sample();
    chk("t4_accept", 64'(ready_seen), 64'd1);
    adv();
    mWbValid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      new_c();
      sample();
      chk("t4_no_stall", 64'(stallCore), 64'd0);
      adv();
    end
    new_c();
    held_reg = coreWbReg;
    sample();
    chk("t4_force_stall", 64'(stallCore), 64'd1);
    chk("t4_force_reg", 64'(writeRegister), 64'd7);
    chk("t4_force_data", 64'(writeData), 64'h0000_7777);
    adv();
    sample();
    chk("t4_resume_stall", 64'(stallCore), 64'd0);
    chk("t4_resume_reg", 64'(writeRegister), 64'(held_reg));
    adv();
    coreWbValid = 1'b0;

    // Test 5: x0 requests.
    new_c();
    m_drive(5'd9, 32'h0000_9999);
    sample(); adv();
    mWbValid = 1'b0;
    coreWbValid = 1'b1; coreWbReg = 5'd0; coreWbData = 32'hBAD0_0000;
    sample();
    chk("t5_head_we", 64'(regWriteEnable), 64'd1);
    chk("t5_head_reg", 64'(writeRegister), 64'd9);
    chk("t5_no_stall", 64'(stallCore), 64'd0);
    adv();
    coreWbValid = 1'b0;
    m_drive(5'd0, 32'hBAD1_0000);
    sample();
    chk("t5_x0_ready", 64'(mWbReady), 64'd1);
    chk("t5_x0_we", 64'(regWriteEnable), 64'd0);
    adv();
    mWbValid = 1'b0;
    sample();
    chk("t5_x0_after_we", 64'(regWriteEnable), 64'd0);
    chk("t5_x0_mask", 64'(pendingMask), 64'd0);
    adv();

    // Test 6: enqueue and dequeue together at count=DEPTH-1, across the pointer wrap.
    for (int i = 0; i < 3; i++) begin
      new_c();
      m_drive(5'(10 + i), 32'h6000_0000 + 32'(i));
      sample(); adv();
    end
    coreWbValid = 1'b0;
    m_drive(5'd13, 32'h6000_0003);
    sample();
    chk("t6_mask_before", 64'(pendingMask), 64'h0000_1C00);
    chk("t6_ready", 64'(mWbReady), 64'd1);
    chk("t6_head_reg", 64'(writeRegister), 64'd10);
    adv();
    m_drive(5'd14, 32'h6000_0004);
    sample();
    chk("t6_mask_mid", 64'(pendingMask), 64'h0000_3800);
    chk("t6_ready_mid", 64'(mWbReady), 64'd1);
    adv();
    mWbValid = 1'b0;
    sample();
    chk("t6_mask_after", 64'(pendingMask), 64'h0000_7000);
    adv();
    for (int i = 0; i < 6; i++) begin
      sample(); adv();
    end
    chk("t6_m_drained", 64'(mq.size()), 64'd0);
    chk("t6_c_drained", 64'(cq.size()), 64'd0);
    chk("t6_final_mask", 64'(pendingMask), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
